inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Consumer side of the PC interface: accepts fetch addresses from the PC unit, reads instruction memory
//  over a req/ack handshake of variable latency, and queues {pc, instr} pairs for decode (valid/ready).
//  Back-pressures the PC unit via pc_ready; flush discards queued and in-flight fetches on redirect.
// PARAMETERS
//  DEPTH     4   queue entries (power of 2, >=2)
//  PC_W      32  fetch address width
//  INSTR_W   32  instruction width
// PORTS
//  clk          in   1        rising-edge clock
//  ReSet_n      in   1        asynchronous active-low reset
//  pc_valid     in   1        PC unit offers fetch address
//  pc_in        in   PC_W     fetch address
//  pc_ready     out  1        address accepted when pc_valid&pc_ready
//  flush        in   1        redirect: drop queue + in-flight fetch
//  imem_req     out  1        memory request, held until imem_ack
//  imem_addr    out  PC_W     request address, stable while imem_req
//  imem_ack     in   1        response valid (only honoured while imem_req=1)
//  imem_rdata   in   INSTR_W  instruction word, valid with imem_ack
//  out_valid    out  1        queue head valid
//  out_ready    in   1        decode consumes head
//  out_pc       out  PC_W     head fetch address
//  out_instr    out  INSTR_W  head instruction
//  out_fault    out  1        head address misaligned (instr forced 0)
// BEHAVIOUR
//  - Reset: state IDLE, queue empty, all outputs 0; takes effect immediately (async), no pending req survives.
//  - FSM: IDLE -> BUSY on accept of aligned pc; BUSY -> IDLE on imem_ack (push entry);
//    BUSY -> DROP on flush without ack; DROP -> IDLE on imem_ack (data discarded).
//  - pc_ready = (state==IDLE) & ~flush & (count < DEPTH); count includes reserved in-flight slot.
//  - Accept cycle N: imem_req=1, imem_addr=pc_in from N+1; earliest ack N+1; out_valid earliest N+2.
//  - Misaligned pc_in[1:0]!=0: no memory request; entry {pc_in, 0, fault=1} pushed next cycle, stays IDLE.
//  - Queue is FIFO, pointer wrap modulo DEPTH; push and pop same cycle keep count unchanged; push
//    never occurs when full (guaranteed by reservation). Head outputs are registered queue contents.
//  - flush: next cycle queue empty, out_valid=0; a pop in the flush cycle is ignored;
//    ack in same cycle as flush -> data dropped, state IDLE; BUSY+flush without ack -> DROP,
//    imem_req stays high with same addr until ack, pc_ready=0 throughout DROP.
//  - Back-to-back: max one fetch outstanding; sustained throughput 1 instr / 2 cycles with ack at N+1.
// CONFIGURATION
//  PREDECODE_EN defined: extra outputs registered per entry, valid with head:
//    out_is_branch (opcode 6'b000100 beq), out_is_jump (opcode 6'b000010 j),
//    out_br_off [31:0] = sign-extended instr[15:0] (word offset, PC unit shifts by 2),
//    out_j_idx [25:0] = instr[25:0]; all 0 when out_fault=1 or queue empty.
//  PREDECODE_EN undefined: those ports and their storage absent; rest identical.
// TESTING
//  1 Reset low mid-BUSY -> imem_req=0, out_valid=0, pc_ready=1 same cycle; after release first
//    pc_in=32'h0000_3000 gives imem_addr=32'h0000_3000 next cycle.
//  2 pcs 0x3000,0x3004,0x3008, ack at +1, out_ready=1 -> out_pc in order, one entry every 2 cycles.
//  3 out_ready=0, DEPTH=4: 4 fetches complete, pc_ready=0 with count=4; single pop -> pc_ready=1 next cycle.
//  4 flush during BUSY, ack 3 cycles later rdata=32'hDEAD_BEEF -> never on out_*, pc_ready=0 until ack.
//  5 pc_in=32'h0000_3002 -> no imem_req, out_fault=1, out_instr=0, out_pc=32'h0000_3002.
//  6 PREDECODE_EN, instr 32'h1000_FFFE -> out_is_branch=1, out_br_off=32'hFFFF_FFFE;
//    instr 32'h0800_0C01 -> out_is_jump=1, out_j_idx=26'h000_0C01.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Consumer side of the PC interface. Takes fetch addresses from the PC unit
//   and reads instruction memory over a req/ack handshake of variable latency.
//   The resulting {pc, instr, fault} entries are queued in a FIFO for decode.
//   At most one memory fetch is outstanding at a time. A flush empties the
//   queue. It also discards a fetch that is still in flight: the memory
//   handshake is completed, but the returned data is not queued.
//
//   Optional feature macro: PREDECODE_EN
//     When defined, each entry also stores predecode fields, and extra head
//     outputs are present:
//       out_is_branch (beq), out_is_jump (j), out_br_off, out_j_idx.
//
// Ports
//   clk         rising-edge clock
//   ReSet_n     asynchronous active-low reset
//   pc_valid    PC unit offers a fetch address
//   pc_in       fetch address
//   pc_ready    address is accepted when pc_valid & pc_ready
//   flush       redirect: drop the queue and any in-flight fetch
//   imem_req    memory request, held high until imem_ack
//   imem_addr   request address, stable while imem_req is high
//   imem_ack    response valid (only honoured while imem_req is high)
//   imem_rdata  instruction word, valid together with imem_ack
//   out_valid   queue head valid
//   out_ready   decode consumes the head entry
//   out_pc      head fetch address
//   out_instr   head instruction (0 for faulted entries)
//   out_fault   head address was misaligned
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               ReSet_n,
   input  logic               pc_valid,
   input  logic [PC_W-1:0]    pc_in,
   output logic               pc_ready,
   input  logic               flush,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
`ifdef PREDECODE_EN
   output logic               out_is_branch,
   output logic               out_is_jump,
   output logic [31:0]        out_br_off,
   output logic [25:0]        out_j_idx,
`endif
   output logic               out_fault
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e              state_q;
   logic                imem_req_q;
   logic [PC_W-1:0]     imem_addr_q;

   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [PC_W-1:0]     pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
   logic                fault_mem_q [DEPTH];

   logic                accept_s;
   logic                misalign_s;
   logic                ack_s;
   logic                push_s;
   logic                pop_s;
   logic [PC_W-1:0]     push_pc_s;
   logic [INSTR_W-1:0]  push_instr_s;
   logic                push_fault_s;
   logic                head_valid_s;

`ifdef PREDECODE_EN
   logic                br_mem_q   [DEPTH];
   logic                jmp_mem_q  [DEPTH];
   logic [31:0]         off_mem_q  [DEPTH];
   logic [25:0]         jidx_mem_q [DEPTH];

   // Predecode helpers (MIPS-style opcode in bits 31:26)
   function automatic logic f_is_branch(input logic [31:0] w);
      return (w[31:26] == 6'b000100);
   endfunction

   function automatic logic f_is_jump(input logic [31:0] w);
      return (w[31:26] == 6'b000010);
   endfunction

   function automatic logic [31:0] f_br_off(input logic [31:0] w);
      return {{16{w[15]}}, w[15:0]};
   endfunction
`endif

   // No new address is taken while a fetch is outstanding. The queue count
   // cannot grow past DEPTH, because a fetch is only started when a slot is
   // free, and only one fetch can be in flight at a time.
   assign pc_ready   = (state_q == ST_IDLE) & ~flush & (cnt_q < CW'(DEPTH));
   assign accept_s   = pc_valid & pc_ready;
   assign misalign_s = (pc_in[1:0] != 2'b00);
   assign ack_s      = imem_ack & imem_req_q;
   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;

   // Push source: misaligned addresses bypass memory; otherwise the memory response
   always_comb begin
      push_s       = 1'b0;
      push_pc_s    = imem_addr_q;
      push_instr_s = imem_rdata;
      push_fault_s = 1'b0;
      if (accept_s && misalign_s) begin
         push_s       = 1'b1;
         push_pc_s    = pc_in;
         push_instr_s = '0;
         push_fault_s = 1'b1;
      end else if ((state_q == ST_BUSY) && ack_s && !flush) begin
         push_s       = 1'b1;
      end else begin
         push_s       = 1'b0;
      end
   end

   assign head_valid_s = (cnt_q != '0);
   assign pop_s        = head_valid_s & out_ready & ~flush;

   // Queue pointer and occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Queue control registers
   always_ff @(posedge clk or negedge ReSet_n) begin
      if (!ReSet_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Fetch FSM: owns the memory request and its address
   always_ff @(posedge clk or negedge ReSet_n) begin
      if (!ReSet_n) begin
         state_q     <= ST_IDLE;
         imem_req_q  <= 1'b0;
         imem_addr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && !misalign_s) begin
                  state_q     <= ST_BUSY;
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= pc_in;
               end
            end
            ST_BUSY: begin
               if (ack_s) begin
                  state_q    <= ST_IDLE;
                  imem_req_q <= 1'b0;
               end else if (flush) begin
                  // Request stays up with the same address; the data will be discarded
                  state_q <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (ack_s) begin
                  state_q    <= ST_IDLE;
                  imem_req_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Entry storage; contents are only visible while counted as valid
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_q[wr_ptr_q]    <= push_pc_s;
         instr_mem_q[wr_ptr_q] <= push_instr_s;
         fault_mem_q[wr_ptr_q] <= push_fault_s;
`ifdef PREDECODE_EN
         br_mem_q[wr_ptr_q]    <= ~push_fault_s & f_is_branch(push_instr_s);
         jmp_mem_q[wr_ptr_q]   <= ~push_fault_s & f_is_jump(push_instr_s);
         off_mem_q[wr_ptr_q]   <= push_fault_s ? 32'h0000_0000 : f_br_off(push_instr_s);
         jidx_mem_q[wr_ptr_q]  <= push_fault_s ? 26'h000_0000 : push_instr_s[25:0];
`endif
      end
   end

   // Head outputs are forced to zero when the queue is empty
   assign out_valid = head_valid_s;
   assign out_pc    = head_valid_s ? pc_mem_q[rd_ptr_q]    : '0;
   assign out_instr = head_valid_s ? instr_mem_q[rd_ptr_q] : '0;
   assign out_fault = head_valid_s & fault_mem_q[rd_ptr_q];

`ifdef PREDECODE_EN
   assign out_is_branch = head_valid_s & br_mem_q[rd_ptr_q];
   assign out_is_jump   = head_valid_s & jmp_mem_q[rd_ptr_q];
   assign out_br_off    = head_valid_s ? off_mem_q[rd_ptr_q]  : 32'h0000_0000;
   assign out_j_idx     = head_valid_s ? jidx_mem_q[rd_ptr_q] : 26'h000_0000;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed bench for inst_fetch_queue, using DEPTH=4 and 32-bit widths.
//   Inputs change 1 time unit after the rising edge. Outputs are checked a
//   further 1 time unit later, in the same cycle.
//   Define PREDECODE_EN to also exercise the predecode outputs.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

   logic        clk;
   logic        ReSet_n;
   logic        pc_valid;
   logic [31:0] pc_in;
   logic        pc_ready;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;
`ifdef PREDECODE_EN
   logic        out_is_branch;
   logic        out_is_jump;
   logic [31:0] out_br_off;
   logic [25:0] out_j_idx;
`endif

   int checks_cnt = 0;
   int errors_cnt = 0;

   inst_fetch_queue #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) dut (
      .clk           (clk),
      .ReSet_n       (ReSet_n),
      .pc_valid      (pc_valid),
      .pc_in         (pc_in),
      .pc_ready      (pc_ready),
      .flush         (flush),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_instr     (out_instr),
`ifdef PREDECODE_EN
      .out_is_branch (out_is_branch),
      .out_is_jump   (out_is_jump),
      .out_br_off    (out_br_off),
      .out_j_idx     (out_j_idx),
`endif
      .out_fault     (out_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One aligned fetch, with the memory ack in the cycle right after acceptance
   task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
      pc_valid   = 1'b1;
      pc_in      = pc;
      cyc();
      pc_valid   = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = data;
      cyc();
      imem_ack   = 1'b0;
      #1;
   endtask

   // Consume the head entry for one cycle
   task automatic pop();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ReSet_n    = 1'b0;
      pc_valid   = 1'b0;
      pc_in      = 32'h0000_0000;
      flush      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0000_0000;
      out_ready  = 1'b0;
      cyc();
      cyc();
      ReSet_n = 1'b1;
      #1;

      // ---- reset state ----
      chk("rst_req",   64'(imem_req),  64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_ready", 64'(pc_ready),  64'h1);
      chk("rst_instr", 64'(out_instr), 64'h0);
      chk("rst_fault", 64'(out_fault), 64'h0);

      // ---- 1: reset asserted mid-BUSY ----
      pc_valid = 1'b1;
      pc_in    = 32'h0000_1000;
      cyc();
      pc_valid = 1'b0;
      #1;
      chk("t1_busy_req",   64'(imem_req),  64'h1);
      chk("t1_busy_addr",  64'(imem_addr), 64'h0000_1000);
      chk("t1_busy_ready", 64'(pc_ready),  64'h0);
      ReSet_n = 1'b0;
      #1;
      chk("t1_async_req",   64'(imem_req),  64'h0);
      chk("t1_async_valid", 64'(out_valid), 64'h0);
      chk("t1_async_ready", 64'(pc_ready),  64'h1);
      cyc();
      ReSet_n  = 1'b1;
      pc_valid = 1'b1;
      pc_in    = 32'h0000_3000;
      cyc();
      pc_valid   = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0013;
      #1;
      chk("t1_addr", 64'(imem_addr), 64'h0000_3000);
      cyc();
      imem_ack = 1'b0;
      #1;
      chk("t1_out_pc", 64'(out_pc), 64'h0000_3000);
      pop();
      chk("t1_empty", 64'(out_valid), 64'h0);

      // ---- 2: back-to-back fetches, one entry every 2 cycles ----
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_valid = 1'b1;
         pc_in    = 32'h0000_3000 + 32'(4 * i);
         #1;
         chk("t2_ready", 64'(pc_ready), 64'h1);
         if (i > 0) begin
            chk("t2_valid", 64'(out_valid), 64'h1);
            chk("t2_pc",    64'(out_pc),    64'(32'h0000_3000 + 32'(4 * (i - 1))));
            chk("t2_instr", 64'(out_instr), 64'(32'h0200_0000 + 32'(i - 1)));
         end
         cyc();
         pc_valid   = 1'b0;
         imem_ack   = 1'b1;
         imem_rdata = 32'h0200_0000 + 32'(i);
         #1;
         chk("t2_gap",  64'(out_valid), 64'h0);
         chk("t2_addr", 64'(imem_addr), 64'(32'h0000_3000 + 32'(4 * i)));
         cyc();
         imem_ack = 1'b0;
      end
      #1;
      chk("t2_last_pc",    64'(out_pc),    64'h0000_3008);
      chk("t2_last_instr", 64'(out_instr), 64'h0200_0002);
      cyc();
      out_ready = 1'b0;
      #1;
      chk("t2_drained", 64'(out_valid), 64'h0);

      // ---- 3: fill to DEPTH, back-pressure, single pop ----
      for (int i = 0; i < 4; i++) begin
         chk("t3_ready_fill", 64'(pc_ready), 64'h1);
         fetch(32'h0000_4000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      end
      chk("t3_full_ready", 64'(pc_ready), 64'h0);
      chk("t3_head_pc",    64'(out_pc),   64'h0000_4000);
      pc_valid = 1'b1;
      pc_in    = 32'h0000_4100;
      cyc();
      pc_valid = 1'b0;
      #1;
      chk("t3_no_req", 64'(imem_req), 64'h0);
      pop();
      chk("t3_ready_after_pop", 64'(pc_ready), 64'h1);
      for (int i = 1; i < 4; i++) begin
         chk("t3_order_pc",    64'(out_pc),    64'(32'h0000_4000 + 32'(4 * i)));
         chk("t3_order_instr", 64'(out_instr), 64'(32'hA000_0000 + 32'(i)));
         pop();
      end
      chk("t3_empty", 64'(out_valid), 64'h0);

      // ---- 4: flush while BUSY, late ack is dropped ----
      fetch(32'h0000_4F00, 32'h1111_1111);
      chk("t4_pre_valid", 64'(out_valid), 64'h1);
      pc_valid = 1'b1;
      pc_in    = 32'h0000_5000;
      cyc();
      pc_valid  = 1'b0;
      flush     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("t4_flush_ready", 64'(pc_ready), 64'h0);
      cyc();
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("t4_q_empty",  64'(out_valid), 64'h0);
      chk("t4_drop_req", 64'(imem_req),  64'h1);
      chk("t4_drop_addr", 64'(imem_addr), 64'h0000_5000);
      chk("t4_drop_ready", 64'(pc_ready), 64'h0);
      cyc();
      chk("t4_drop_ready2", 64'(pc_ready), 64'h0);
      chk("t4_drop_req2",   64'(imem_req), 64'h1);
      cyc();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t4_drop_ready3", 64'(pc_ready), 64'h0);
      cyc();
      imem_ack = 1'b0;
      #1;
      chk("t4_no_out",    64'(out_valid), 64'h0);
      chk("t4_idle_req",  64'(imem_req),  64'h0);
      chk("t4_idle_ready", 64'(pc_ready), 64'h1);
      fetch(32'h0000_6000, 32'h2222_2222);
      chk("t4_post_pc",    64'(out_pc),    64'h0000_6000);
      chk("t4_post_instr", 64'(out_instr), 64'h2222_2222);
      pop();
      chk("t4_post_empty", 64'(out_valid), 64'h0);
      // ack in the same cycle as flush
      pc_valid = 1'b1;
      pc_in    = 32'h0000_6100;
      cyc();
      pc_valid   = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h3333_3333;
      flush      = 1'b1;
      cyc();
      imem_ack = 1'b0;
      flush    = 1'b0;
      #1;
      chk("t4b_req",   64'(imem_req),  64'h0);
      chk("t4b_valid", 64'(out_valid), 64'h0);
      chk("t4b_ready", 64'(pc_ready),  64'h1);

      // ---- 5: misaligned address ----
      pc_valid = 1'b1;
      pc_in    = 32'h0000_3002;
      cyc();
      pc_valid = 1'b0;
      #1;
      chk("t5_no_req", 64'(imem_req),  64'h0);
      chk("t5_valid",  64'(out_valid), 64'h1);
      chk("t5_fault",  64'(out_fault), 64'h1);
      chk("t5_instr",  64'(out_instr), 64'h0);
      chk("t5_pc",     64'(out_pc),    64'h0000_3002);
      chk("t5_ready",  64'(pc_ready),  64'h1);
`ifdef PREDECODE_EN
      chk("t5_pd_off", 64'(out_br_off), 64'h0);
`endif
      pop();
      chk("t5_empty", 64'(out_valid), 64'h0);

`ifdef PREDECODE_EN
      // ---- 6: predecode fields ----
      fetch(32'h0000_7000, 32'h1000_FFFE);
      chk("t6_is_branch", 64'(out_is_branch), 64'h1);
      chk("t6_not_jump",  64'(out_is_jump),   64'h0);
      chk("t6_br_off",    64'(out_br_off),    64'hFFFF_FFFE);
      pop();
      fetch(32'h0000_7004, 32'h0800_0C01);
      chk("t6_is_jump",    64'(out_is_jump),   64'h1);
      chk("t6_not_branch", 64'(out_is_branch), 64'h0);
      chk("t6_j_idx",      64'(out_j_idx),     64'h000_0C01);
      pop();
      chk("t6_empty_jidx", 64'(out_j_idx), 64'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
